// File: rtl/wb_pkg.sv
// Shared encodings and constants for the MEM/WB writeback stage.
package wb_pkg;

    typedef enum logic [1:0] {
        RDST_RD   = 2'd0,
        RDST_RT   = 2'd1,
        RDST_LINK = 2'd2,
        RDST_RSV  = 2'd3
    } rdst_e;

    typedef enum logic [1:0] {
        RWD_ALU  = 2'd0,
        RWD_MEM  = 2'd1,
        RWD_LINK = 2'd2,
        RWD_RSV  = 2'd3
    } rwd_e;

    typedef enum logic [1:0] {
        SIZE_B   = 2'd0,
        SIZE_H   = 2'd1,
        SIZE_W   = 2'd2,
        SIZE_RSV = 2'd3
    } size_e;

    localparam int PC_LINK_OFS = 8;

endpackage

// File: rtl/wb_stage_if.sv
// MEM->WB bus plus regfile write port, forwarding tap and retire counter.
interface wb_stage_if #(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int RETIRE_W = 32
);
    // Handshake: an instruction transfers on a rising edge where mem_valid && mem_ready;
    // mem_ready is simply !wb_stall, and wb_flush discards whatever would have transferred.
    logic              mem_valid;
    logic              mem_ready;
    logic              wb_stall;
    logic              wb_flush;
    logic [DATA_W-1:0] mem_o;
    logic [DATA_W-1:0] mem_d;
    logic [DATA_W-1:0] mem_pc;
    logic [31:0]       mem_insn;
    logic              mem_rwe;
    logic [1:0]        mem_rdst;
    logic [1:0]        mem_rwd;
    logic [1:0]        mem_size;
    logic              mem_sext;

    logic                rf_we;
    logic [REG_AW-1:0]   rf_waddr;
    logic [DATA_W-1:0]   rf_wdata;
    logic                fwd_valid;
    logic [REG_AW-1:0]   fwd_addr;
    logic [DATA_W-1:0]   fwd_data;
    logic [RETIRE_W-1:0] retire_cnt;

    modport master (
        output mem_valid, wb_stall, wb_flush, mem_o, mem_d, mem_pc, mem_insn,
               mem_rwe, mem_rdst, mem_rwd, mem_size, mem_sext,
        input  mem_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr,
               fwd_data, retire_cnt
    );

    modport slave (
        input  mem_valid, wb_stall, wb_flush, mem_o, mem_d, mem_pc, mem_insn,
               mem_rwe, mem_rdst, mem_rwd, mem_size, mem_sext,
        output mem_ready, rf_we, rf_waddr, rf_wdata, fwd_valid, fwd_addr,
               fwd_data, retire_cnt
    );

endinterface

// File: rtl/wb_load_align.sv
// Sub-word load lane select and zero/sign extension (used under WB_LOAD_ALIGN_EN).
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] d,
    input  logic [1:0]        lane,
    input  logic [1:0]        size,
    input  logic              sext,
    output logic [DATA_W-1:0] q
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = d[{lane, 3'b000} +: 8];
        half_v = lane[1] ? d[31:16] : d[15:0];
        q      = d;
        case (size_e'(size))
            SIZE_B:  q = {{(DATA_W-8){sext & byte_v[7]}}, byte_v};
            SIZE_H:  q = {{(DATA_W-16){sext & half_v[15]}}, half_v};
            default: q = d;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Registered MEM/WB stage: selects write data/address at capture, writes the regfile once per
// instruction, exposes a forwarding tap and a retire counter. Optional macro: WB_LOAD_ALIGN_EN.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int LINK_REG = 31,
    parameter int RETIRE_W = 32
) (
    input logic       clk,
    input logic       reset,
    wb_stage_if.slave bus
);

    logic [DATA_W-1:0]   load_data;
    logic [DATA_W-1:0]   sel_data;
    logic [REG_AW-1:0]   sel_addr;
    logic                sel_rwe;

    logic                valid_q;
    logic                rwe_q;
    logic                written_q;
    logic [REG_AW-1:0]   addr_q;
    logic [DATA_W-1:0]   data_q;
    logic [RETIRE_W-1:0] retire_q;

`ifdef WB_LOAD_ALIGN_EN
    wb_load_align #(.DATA_W(DATA_W)) u_align (
        .d    (bus.mem_d),
        .lane (bus.mem_o[1:0]),
        .size (bus.mem_size),
        .sext (bus.mem_sext),
        .q    (load_data)
    );
`else
    logic unused_load;
    assign unused_load = ^{bus.mem_size, bus.mem_sext};
    assign load_data   = bus.mem_d;
`endif

    logic unused_insn;
    assign unused_insn = ^{bus.mem_insn[31:21], bus.mem_insn[10:0]};

    always_comb begin
        sel_addr = '0;
        case (rdst_e'(bus.mem_rdst))
            RDST_RD:   sel_addr = REG_AW'(bus.mem_insn[15:11]);
            RDST_RT:   sel_addr = REG_AW'(bus.mem_insn[20:16]);
            RDST_LINK: sel_addr = REG_AW'(LINK_REG);
            default:   sel_addr = '0;
        endcase

        // r0 and the reserved destination never reach the regfile.
        sel_rwe = bus.mem_rwe && (rdst_e'(bus.mem_rdst) != RDST_RSV) && (sel_addr != '0);

        sel_data = '0;
        case (rwd_e'(bus.mem_rwd))
            RWD_ALU:  sel_data = bus.mem_o;
            RWD_MEM:  sel_data = load_data;
            RWD_LINK: sel_data = bus.mem_pc + DATA_W'(PC_LINK_OFS);
            default:  sel_data = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= 1'b0;
            rwe_q     <= 1'b0;
            written_q <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            retire_q  <= '0;
        end else begin
            if (valid_q && !written_q && !bus.wb_flush)
                retire_q <= retire_q + RETIRE_W'(1);

            if (bus.wb_flush) begin
                valid_q   <= 1'b0;
                written_q <= 1'b0;
            end else if (bus.wb_stall) begin
                // A held entry has already written/retired after its first resident cycle.
                written_q <= written_q | valid_q;
            end else begin
                valid_q   <= bus.mem_valid;
                written_q <= 1'b0;
                rwe_q     <= sel_rwe;
                addr_q    <= sel_addr;
                data_q    <= sel_data;
            end
        end
    end

    assign bus.mem_ready  = !bus.wb_stall;
    assign bus.rf_we      = valid_q && rwe_q && !written_q;
    assign bus.rf_waddr   = addr_q;
    assign bus.rf_wdata   = data_q;
    assign bus.fwd_valid  = valid_q && rwe_q;
    assign bus.fwd_addr   = addr_q;
    assign bus.fwd_data   = data_q;
    assign bus.retire_cnt = retire_q;

endmodule
